// File: rtl/axis_uart_tx_pkg.sv
// Shared helpers for the AXI-stream UART transmitter: line levels and counter sizing.
package axis_uart_tx_pkg;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Width of a down-counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_uart_tx_baud.sv
// Bit-time counter: counts CLOCK_DIV-1 down to 0; tick marks the last cycle of a bit time.
module axis_uart_baud
  import axis_uart_tx_pkg::*;
#(
  parameter int unsigned CLOCK_DIV = 104
) (
  input  logic clock,
  input  logic resetn,
  input  logic restart,
  output logic tick,
  output logic pretick
);

  localparam int unsigned   CW     = cnt_w(CLOCK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLOCK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Reload on restart or after the terminal count so the sequence never wraps through all-ones.
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (restart || (cnt_q == '0)) cnt_d = RELOAD;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick    = (cnt_q == '0);
  // Lets the owner register a signal that must be high exactly in the tick cycle.
  assign pretick = (cnt_d == '0);

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-stream to UART transmitter: one frame per accepted word, back-to-back with no idle gap.
module axis_uart_tx
  import axis_uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CLOCK_DIV = 104,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] idata,
  input  logic             ivalid,
  output logic             iready,
  output logic             txd,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int unsigned   BW        = cnt_w(WIDTH + STOP_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             txd_q, txd_d;
  logic             iready_q, iready_d;
  logic             busy_q, busy_d;
  logic             xfer, tick, pretick;

  assign xfer = ivalid && iready_q;

  axis_uart_baud #(
    .CLOCK_DIV(CLOCK_DIV)
  ) u_baud (
    .clock  (clock),
    .resetn (resetn),
    .restart(xfer),
    .tick   (tick),
    .pretick(pretick)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      txd_q    <= LINE_IDLE;
      iready_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      txd_q    <= txd_d;
      iready_q <= iready_d;
      busy_q   <= busy_d;
    end
  end

  // bit_q indexes data bits in DATA and stop bits in STOP.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_START;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == LAST_DATA) begin
            state_d = ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (xfer) begin
          state_d = ST_START;
          bit_d   = '0;
        end else if (tick) begin
          if (bit_q == LAST_STOP) begin
            state_d = ST_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift register holds the word; bit 0 is always the next data bit to send.
  always_comb begin
    shreg_d = shreg_q;
    if (xfer)                            shreg_d = idata;
    else if ((state_q == ST_DATA) && tick) shreg_d = {1'b1, shreg_q[WIDTH-1:1]};
  end

  always_ff @(posedge clock) begin
    shreg_q <= shreg_d;
  end

  // Outputs are registered from the next state so they line up with the frame cycles.
  always_comb begin
    case (state_d)
      ST_START: txd_d = LINE_START;
      ST_DATA:  txd_d = shreg_d[0];
      default:  txd_d = LINE_IDLE;
    endcase
    busy_d   = (state_d != ST_IDLE);
    iready_d = (state_d == ST_IDLE) ||
               ((state_d == ST_STOP) && (bit_d == LAST_STOP) && pretick);
  end

  assign iready = iready_q;
  assign txd    = txd_q;
  assign busy   = busy_q;

endmodule
